// File: rtl/im_loader.sv
// Boot-time loader: framed big-endian byte stream -> sequential instruction-memory writes,
// holding the core in reset until done. Define IM_LOADER_CSUM_EN for the trailing XOR checksum byte.
module im_loader #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              restart,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              core_rst_f,
  output logic              load_done,
  output logic              csum_err
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ASM_W  = WORD_W - BYTE_W;

  typedef enum logic [2:0] {
    S_HDR_HI = 3'd0,
    S_HDR_LO = 3'd1,
    S_DATA   = 3'd2,
`ifdef IM_LOADER_CSUM_EN
    S_CSUM   = 3'd3,
`endif
    S_DONE   = 3'd4
  } state_e;

  // State entered once the header/payload is exhausted.
`ifdef IM_LOADER_CSUM_EN
  localparam state_e S_TAIL = S_CSUM;
`else
  localparam state_e S_TAIL = S_DONE;
`endif

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   n_hi_q, n_hi_d;
  logic [CNT_W-1:0]    wrem_q, wrem_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [ASM_W-1:0]    asm_q, asm_d;
  logic                in_ready_q, in_ready_d;
  logic                im_we_q, im_we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          fin_q, fin_d;
  logic                done_q, done_d;
  logic                core_rst_q, core_rst_d;
`ifdef IM_LOADER_CSUM_EN
  logic [BYTE_W-1:0]   xor_q, xor_d;
  logic                bad_q, bad_d;
  logic                csum_err_q, csum_err_d;
`endif

  logic take_c;
  assign take_c = in_valid && in_ready_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    n_hi_d     = n_hi_q;
    wrem_d     = wrem_q;
    bcnt_d     = bcnt_q;
    asm_d      = asm_q;
    im_we_d    = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    core_rst_d = core_rst_q;
`ifdef IM_LOADER_CSUM_EN
    xor_d      = xor_q;
    bad_d      = bad_q;
    csum_err_d = csum_err_q;
`endif

    if (im_we_q) begin
      addr_d = addr_q + ADDR_W'(1);
    end

    // Completion lands two edges after the final byte so release never overlaps the last write.
    if (fin_q[1]) begin
      done_d = 1'b1;
`ifdef IM_LOADER_CSUM_EN
      core_rst_d = ~bad_q;
      csum_err_d = bad_q;
`else
      core_rst_d = 1'b1;
`endif
    end

    case (state_q)
      S_HDR_HI: begin
        if (take_c) begin
          n_hi_d  = in_data;
`ifdef IM_LOADER_CSUM_EN
          xor_d   = in_data;
`endif
          state_d = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (take_c) begin
          wrem_d  = {n_hi_q, in_data};
          bcnt_d  = 2'd0;
`ifdef IM_LOADER_CSUM_EN
          xor_d   = xor_q ^ in_data;
`endif
          state_d = ({n_hi_q, in_data} == CNT_W'(0)) ? S_TAIL : S_DATA;
        end
      end
      S_DATA: begin
        if (take_c) begin
`ifdef IM_LOADER_CSUM_EN
          xor_d  = xor_q ^ in_data;
`endif
          asm_d  = {asm_q[ASM_W-BYTE_W-1:0], in_data};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            im_we_d = 1'b1;
            wdata_d = {asm_q, in_data};
            wrem_d  = wrem_q - CNT_W'(1);
            if (wrem_q == CNT_W'(1)) begin
              state_d = S_TAIL;
            end
          end
        end
      end
`ifdef IM_LOADER_CSUM_EN
      S_CSUM: begin
        if (take_c) begin
          bad_d   = (in_data != xor_q);
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (restart) begin
          state_d    = S_HDR_HI;
          done_d     = 1'b0;
          core_rst_d = 1'b0;
          addr_d     = '0;
`ifdef IM_LOADER_CSUM_EN
          csum_err_d = 1'b0;
`endif
        end
      end
      default: begin
        state_d = S_HDR_HI;
      end
    endcase

    fin_d[0]   = (state_d == S_DONE) && (state_q != S_DONE);
    fin_d[1]   = fin_q[0] && !((state_q == S_DONE) && restart);
    in_ready_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state_q    <= S_HDR_HI;
      n_hi_q     <= '0;
      wrem_q     <= '0;
      bcnt_q     <= '0;
      asm_q      <= '0;
      in_ready_q <= 1'b0;
      im_we_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      fin_q      <= '0;
      done_q     <= 1'b0;
      core_rst_q <= 1'b0;
`ifdef IM_LOADER_CSUM_EN
      xor_q      <= '0;
      bad_q      <= 1'b0;
      csum_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      n_hi_q     <= n_hi_d;
      wrem_q     <= wrem_d;
      bcnt_q     <= bcnt_d;
      asm_q      <= asm_d;
      in_ready_q <= in_ready_d;
      im_we_q    <= im_we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      fin_q      <= fin_d;
      done_q     <= done_d;
      core_rst_q <= core_rst_d;
`ifdef IM_LOADER_CSUM_EN
      xor_q      <= xor_d;
      bad_q      <= bad_d;
      csum_err_q <= csum_err_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign im_we      = im_we_q;
  assign im_addr    = addr_q;
  assign im_wdata   = wdata_q;
  assign core_rst_f = core_rst_q;
  assign load_done  = done_q;
`ifdef IM_LOADER_CSUM_EN
  assign csum_err   = csum_err_q;
`else
  assign csum_err   = 1'b0;
`endif

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: table vectors, hand-written corner sequences and random frames
// checked against a frame-parsing reference model.
`timescale 1ns/1ps
module tb_im_loader;
  localparam int unsigned ADDR_W = 16;

  logic              clk;
  logic              rst_f;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              restart;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              core_rst_f;
  logic              load_done;
  logic              csum_err;

  im_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .restart    (restart),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .core_rst_f (core_rst_f),
    .load_done  (load_done),
    .csum_err   (csum_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({in_ready, im_we, im_addr, im_wdata, core_rst_f, load_done, csum_err});
  endfunction

  // Write monitor, sampled mid-cycle.
  logic [ADDR_W-1:0] cap_addr[$];
  logic [31:0]       cap_data[$];
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      cap_addr.push_back(im_addr);
      cap_data.push_back(im_wdata);
      chk("core_held_during_write", 64'(core_rst_f), 64'd0);
    end
  end

  // Frame construction and reference model.
  logic [7:0]        frame_q[$];
  logic [31:0]       wbuf[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic [31:0]       exp_data[$];
  bit                exp_err;

  task automatic build_frame(input bit corrupt);
    int unsigned n;
    logic [7:0]  x;
    n = wbuf.size();
    frame_q.delete();
    frame_q.push_back(8'(n >> 8));
    frame_q.push_back(8'(n));
    foreach (wbuf[i]) begin
      for (int b = 3; b >= 0; b--) frame_q.push_back(8'(wbuf[i] >> (8 * b)));
    end
    x = 8'h00;
    foreach (frame_q[i]) x = x ^ frame_q[i];
    x = x ^ {7'd0, corrupt};
`ifdef IM_LOADER_CSUM_EN
    frame_q.push_back(x);
`endif
  endtask

  task automatic model();
    int unsigned n;
    exp_addr.delete();
    exp_data.delete();
    n = 32'({frame_q[0], frame_q[1]});
    for (int unsigned i = 0; i < n; i++) begin
      exp_addr.push_back(ADDR_W'(i));
      exp_data.push_back({frame_q[2 + 4 * i], frame_q[3 + 4 * i], frame_q[4 + 4 * i], frame_q[5 + 4 * i]});
    end
    exp_err = 1'b0;
`ifdef IM_LOADER_CSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < frame_q.size() - 1; i++) x = x ^ frame_q[i];
      exp_err = (x != frame_q[frame_q.size() - 1]);
    end
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int w;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    w = 0;
    while (in_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: byte %0h never accepted", b);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic run_frame(input bit throttle, input string tag);
    cap_addr.delete();
    cap_data.delete();
    model();
    foreach (frame_q[i]) send_byte(frame_q[i], throttle && (i % 2 == 1));
    chk({tag, "_ready_low_in_done"}, 64'(in_ready), 64'd0);
    chk({tag, "_done_e0"}, 64'(load_done), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_done_e1"}, 64'(load_done), 64'd0);
    chk({tag, "_core_rst_e1"}, 64'(core_rst_f), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_done_e2"}, 64'(load_done), 64'd1);
    chk({tag, "_core_rst_e2"}, 64'(core_rst_f), 64'(!exp_err));
    chk({tag, "_csum_err"}, 64'(csum_err), 64'(exp_err));
    chk({tag, "_final_addr"}, 64'(im_addr), 64'(ADDR_W'(exp_addr.size())));
    chk({tag, "_n_writes"}, 64'(cap_addr.size()), 64'(exp_addr.size()));
    if (cap_addr.size() == exp_addr.size()) begin
      foreach (exp_addr[i]) begin
        chk({tag, "_wr_addr"}, 64'(cap_addr[i]), 64'(exp_addr[i]));
        chk({tag, "_wr_data"}, 64'(cap_data[i]), 64'(exp_data[i]));
      end
    end
  endtask

  task automatic do_restart();
    restart  = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    @(posedge clk); #1;
    restart  = 1'b0;
    in_valid = 1'b0;
    chk("restart_core_rst", 64'(core_rst_f), 64'd0);
    chk("restart_done", 64'(load_done), 64'd0);
    chk("restart_csum_err", 64'(csum_err), 64'd0);
    chk("restart_addr", 64'(im_addr), 64'd0);
    chk("restart_ready", 64'(in_ready), 64'd1);
  endtask

  typedef struct {
    int unsigned n;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          throttle;
    bit          corrupt;
    int unsigned exp_writes;
    logic [31:0] exp_last;
    bit          exp_err;
  } vec_t;

  function automatic vec_t mk(int unsigned n, logic [31:0] w0, logic [31:0] w1, bit thr, bit cor,
                              int unsigned ew, logic [31:0] el, bit ee);
    vec_t v;
    v.n = n; v.w0 = w0; v.w1 = w1; v.throttle = thr; v.corrupt = cor;
    v.exp_writes = ew; v.exp_last = el; v.exp_err = ee;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs.push_back(mk(2, 32'h11223344, 32'hAABBCCDD, 1'b0, 1'b0, 2, 32'hAABBCCDD, 1'b0));
    vecs.push_back(mk(2, 32'h11223344, 32'hAABBCCDD, 1'b1, 1'b0, 2, 32'hAABBCCDD, 1'b0));
    vecs.push_back(mk(0, 32'h0,        32'h0,        1'b0, 1'b0, 0, 32'h0,        1'b0));
    vecs.push_back(mk(1, 32'hDEADBEEF, 32'h0,        1'b1, 1'b0, 1, 32'hDEADBEEF, 1'b0));
`ifdef IM_LOADER_CSUM_EN
    vecs.push_back(mk(2, 32'h11223344, 32'hAABBCCDD, 1'b0, 1'b1, 2, 32'hAABBCCDD, 1'b1));
`endif

    // Reset hold and release.
    rst_f = 1'b0; in_valid = 1'b0; restart = 1'b0; in_data = 8'h00;
    repeat (3) begin
      @(posedge clk); #1;
      chk("reset_outputs", all_outs(), 64'd0);
    end
    rst_f = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", 64'(in_ready), 64'd1);

    foreach (vecs[k]) begin
      if (k != 0) do_restart();
      wbuf.delete();
      if (vecs[k].n > 0) wbuf.push_back(vecs[k].w0);
      if (vecs[k].n > 1) wbuf.push_back(vecs[k].w1);
      build_frame(vecs[k].corrupt);
      run_frame(vecs[k].throttle, "vec");
      chk("vec_writes", 64'(cap_data.size()), 64'(vecs[k].exp_writes));
      chk("vec_err", 64'(csum_err), 64'(vecs[k].exp_err));
      if (vecs[k].exp_writes > 0 && cap_data.size() > 0)
        chk("vec_last_data", 64'(cap_data[$]), 64'(vecs[k].exp_last));
    end

    // Mid-load reset after two payload bytes of word 0.
    do_restart();
    cap_addr.delete();
    cap_data.delete();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    rst_f = 1'b0;
    @(posedge clk); #1;
    chk("midrst_outputs", all_outs(), 64'd0);
    @(posedge clk); #1;
    rst_f = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready", 64'(in_ready), 64'd1);
    chk("midrst_no_write", 64'(cap_data.size()), 64'd0);
    wbuf.delete();
    wbuf.push_back(32'hDEADBEEF);
    build_frame(1'b0);
    run_frame(1'b0, "midrst");
    chk("midrst_single_write", 64'(cap_data.size()), 64'd1);
    if (cap_data.size() > 0) begin
      chk("midrst_data", 64'(cap_data[0]), 64'h0000_0000_DEAD_BEEF);
      chk("midrst_addr", 64'(cap_addr[0]), 64'd0);
    end

    // Random frames against the model.
    for (int r = 0; r < 8; r++) begin
      int unsigned n;
      bit thr, cor;
      do_restart();
      n = $urandom_range(0, 5);
      thr = 1'($urandom_range(0, 1));
      cor = ($urandom_range(0, 3) == 0);
      wbuf.delete();
      for (int unsigned i = 0; i < n; i++) wbuf.push_back($urandom);
      build_frame(cor);
      run_frame(thr, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/im_loader.md
# im_loader

Boot-time program loader sitting directly upstream of the SISC core's instruction memory. It accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes those words into sequential instruction-memory addresses from 0, and holds the core in reset until the image is fully written. Only then does it release the core's active-low reset.

## Interface

Parameters:
- ADDR_W, 16, instruction-memory address width; matches the 16-bit PC.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_f  in  1  synchronous, active-low reset
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a byte this cycle
- restart  in  1  re-arm loader from DONE
- im_we  out  1  one-cycle instruction-memory write strobe
- im_addr  out  ADDR_W  write address
- im_wdata  out  32  write data
- core_rst_f  out  1  active-low reset to the core; 0 while loading
- load_done  out  1  load sequence complete
- csum_err  out  1  checksum mismatch; valid when load_done=1

## Operation

- Byte accepted on a rising edge where in_valid && in_ready. No other byte consumption.
- Frame: N_hi, N_lo (16-bit word count N, big-endian), then 4·N payload bytes, MSB first per word, then one checksum byte if IM_LOADER_CSUM_EN.
- FSM states: HDR_HI -> HDR_LO -> DATA -> (CSUM) -> DONE.
  - HDR_HI: latch N[15:8].
  - HDR_LO: latch N[7:0]. If N=0, go to CSUM, or to DONE when checksum is compiled out; otherwise go to DATA.
  - DATA: shift bytes into a 32-bit assembly register. On the 4th byte, copy the word into im_wdata and schedule im_we. After word N, leave DATA.
  - CSUM: accept one byte, compare it to the running XOR, go to DONE.
  - DONE: in_ready=0. restart=1 returns to HDR_HI, clears load_done, csum_err and the address counter, and drives core_rst_f=0. restart is ignored in every other state.
- Address counter starts at 0 and increments after each im_we pulse. It wraps modulo 2^ADDR_W. If N exceeds 2^ADDR_W, earlier words are overwritten; no error is flagged.
- Running XOR covers both header bytes and all payload bytes.
- csum_err=1 forces core_rst_f to stay 0 in DONE; the core remains held in reset.
- rst_f=0 mid-load:
  - aborts the frame with no partial-word write;
  - returns the FSM to HDR_HI;
  - drives all outputs to their reset values.

## Timing

- Reset values:
  - in_ready=0;
  - im_we=0, im_addr=0, im_wdata=0;
  - core_rst_f=0, load_done=0, csum_err=0.
- in_ready is registered. It rises on the first edge with rst_f=1, stays 1 through HDR_HI/HDR_LO/DATA/CSUM, and is 0 in DONE. No back-pressure during word writes, so one byte can be accepted every cycle.
- im_we is high for exactly the cycle after the edge accepting a word's 4th byte. im_addr and im_wdata are stable during that cycle. im_addr advances on the edge ending the pulse.
- Sustained throughput: one word per 4 cycles.
- load_done, core_rst_f and csum_err update on the 2nd rising edge after acceptance of the final frame byte. The core therefore never leaves reset in the same cycle as the last im_we.
- For N=0 without checksum, the final byte is N_lo.
- restart and in_valid high together in DONE: restart wins; no byte is taken that cycle because in_ready=0.

## Configuration

- IM_LOADER_CSUM_EN defined:
  - the frame carries a trailing XOR checksum byte;
  - the CSUM state exists;
  - csum_err is driven as described in Operation.
- IM_LOADER_CSUM_EN undefined:
  - no checksum byte; the frame ends after the last payload byte;
  - the CSUM state is absent;
  - csum_err is tied to 0.

## Test plan

- Reset release: hold rst_f=0 for 3 cycles, then release. Required: all outputs 0 during reset, and in_ready=1 one cycle after release.
- Two-word load, back-to-back bytes:
  - stimulus: 00 02 | 11 22 33 44 | AA BB CC DD, plus checksum 0x00^0x02^…^0xDD if enabled;
  - writes: im_we at addr 0 with 0x11223344, then at addr 1 with 0xAABBCCDD;
  - release: core_rst_f=1 and load_done=1 two edges after the last byte.
- Throttled input: same frame with in_valid toggling 1-0-1. Required: identical writes and values, and no byte lost or duplicated.
- Checksum mismatch (CSUM_EN): send the correct frame with the last byte XOR 0x01. Required: load_done=1, csum_err=1, core_rst_f stays 0.
- Mid-load reset: pull rst_f=0 after 2 payload bytes of word 0, then send a fresh one-word frame 00 01 DE AD BE EF. Required: a single write of 0xDEADBEEF at addr 0.
- Restart and N=0:
  - stimulus: in DONE pulse restart, then send 00 00 (plus checksum 0x00 if enabled);
  - during restart: core_rst_f drops to 0 one edge after restart;
  - after the N=0 frame: no im_we, then load_done=1 and core_rst_f=1 two edges after the final byte.
